// File: rtl/bean_scheduler.sv
// Obstacle scheduler for the goose-run playfield: spawns beans at the right edge,
// scrolls them left on each frame tick, retires them at the left edge and freezes on a hit.
module bean_scheduler #(
    parameter int          NUM_SLOTS = 3,
    parameter int          SPAWN_X   = 700,
    parameter int          SHIFT     = 5,
    parameter int          MIN_GAP   = 200,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   check_hit,
    output logic [10*NUM_SLOTS-1:0] bean_x,
    output logic [NUM_SLOTS-1:0]   bean_type,
    output logic [NUM_SLOTS-1:0]   bean_valid,
    output logic                   bean_passed,
    output logic                   running,
    output logic                   frozen
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam logic [9:0] SHIFT_W = 10'(SHIFT);
    localparam logic [9:0] SPAWN_W = 10'(SPAWN_X);
    localparam logic [9:0] GAP_W   = 10'(MIN_GAP);

    state_t               state_q, state_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] type_q, type_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [9:0]           gap_q, gap_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 passed_d;
    logic                 spawned;
    logic                 lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Start restarts from any state; a hit only matters while running and beats a tick.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        type_d   = type_q;
        valid_d  = valid_q;
        gap_d    = gap_q;
        lfsr_d   = lfsr_q;
        passed_d = 1'b0;
        spawned  = 1'b0;
        if (start) begin
            state_d = RUN;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_d[i] = '0;
            end
            type_d  = '0;
            valid_d = '0;
            gap_d   = '0;
        end else if (state_q == RUN) begin
            if (check_hit) begin
                state_d = HIT;
            end else if (tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (valid_q[i]) begin
                        if (x_q[i] <= SHIFT_W) begin
                            valid_d[i] = 1'b0;
                            x_d[i]     = '0;
                            passed_d   = 1'b1;
                        end else begin
                            x_d[i] = x_q[i] - SHIFT_W;
                        end
                    end
                end
                // Spawn looks at the post-retire occupancy so a freed slot is reused at once.
                if (gap_q <= SHIFT_W) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (!valid_d[i] && !spawned) begin
                            valid_d[i] = 1'b1;
                            x_d[i]     = SPAWN_W;
                            type_d[i]  = lfsr_q[0];
                            spawned    = 1'b1;
                        end
                    end
                    if (spawned) begin
                        gap_d  = GAP_W + {2'b00, lfsr_q[7:1], 1'b0};
                        lfsr_d = {lfsr_q[14:0], lfsr_fb};
                    end
                end else begin
                    gap_d = gap_q - SHIFT_W;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
            end
            type_q      <= '0;
            valid_q     <= '0;
            gap_q       <= '0;
            lfsr_q      <= SEED;
            bean_passed <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            type_q      <= type_d;
            valid_q     <= valid_d;
            gap_q       <= gap_d;
            lfsr_q      <= lfsr_d;
            bean_passed <= passed_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign bean_x[10*g +: 10] = x_q[g];
    end

    assign bean_type  = type_q;
    assign bean_valid = valid_q;
    assign running    = (state_q == RUN);
    assign frozen     = (state_q == HIT);

endmodule

// File: tb/tb_bean_scheduler.sv
// Scoreboard bench for bean_scheduler: a default-parameter instance for the normal run
// and a fast-scrolling instance that fills every slot quickly.
module tb_bean_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick, start, check_hit;
    logic        ftick, fstart, fhit;
    logic [29:0] bean_x, f_bean_x;
    logic [2:0]  bean_type, bean_valid, f_bean_type, f_bean_valid;
    logic        bean_passed, running, frozen;
    logic        f_bean_passed, f_running, f_frozen;

    bean_scheduler dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .check_hit(check_hit),
        .bean_x(bean_x), .bean_type(bean_type), .bean_valid(bean_valid),
        .bean_passed(bean_passed), .running(running), .frozen(frozen)
    );

    bean_scheduler #(.SPAWN_X(1000), .SHIFT(15), .MIN_GAP(0)) u_fast (
        .clk(clk), .reset(reset), .tick(ftick), .start(fstart), .check_hit(fhit),
        .bean_x(f_bean_x), .bean_type(f_bean_type), .bean_valid(f_bean_valid),
        .bean_passed(f_bean_passed), .running(f_running), .frozen(f_frozen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      st;
        logic [2:0][9:0] x;
        logic [2:0]      ty;
        logic [2:0]      v;
        logic [9:0]      gap;
        logic [15:0]     lfsr;
        logic            passed;
    } mdl_t;

    mdl_t        m_main, m_fast;
    logic [38:0] q_main[$];
    logic [38:0] q_fast[$];
    logic [38:0] exp_v, act_v;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic mdl_t model_reset();
        mdl_t m;
        m      = '0;
        m.lfsr = 16'hACE1;
        return m;
    endfunction

    // Reference behaviour: st 0 idle, 1 run, 2 hit.
    function automatic mdl_t model_next(input mdl_t m, input bit tk, input bit st, input bit hit,
                                        input int sx, input int sh, input int mg);
        mdl_t n;
        int   free_idx;
        n        = m;
        n.passed = 1'b0;
        if (st) begin
            n.st  = 2'd1;
            n.x   = '0;
            n.ty  = '0;
            n.v   = '0;
            n.gap = '0;
        end else if (m.st == 2'd1 && hit) begin
            n.st = 2'd2;
        end else if (m.st == 2'd1 && tk) begin
            for (int i = 0; i < 3; i++) begin
                if (m.v[i]) begin
                    if (int'(m.x[i]) <= sh) begin
                        n.v[i]   = 1'b0;
                        n.x[i]   = '0;
                        n.passed = 1'b1;
                    end else begin
                        n.x[i] = 10'(int'(m.x[i]) - sh);
                    end
                end
            end
            if (int'(m.gap) <= sh) begin
                free_idx = -1;
                for (int i = 2; i >= 0; i--) begin
                    if (!n.v[i]) free_idx = i;
                end
                if (free_idx >= 0) begin
                    n.v[free_idx]  = 1'b1;
                    n.x[free_idx]  = 10'(sx);
                    n.ty[free_idx] = m.lfsr[0];
                    n.gap          = 10'(mg + 2 * int'(m.lfsr[7:1]));
                    n.lfsr         = {m.lfsr[14:0], m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
                end
            end else begin
                n.gap = 10'(int'(m.gap) - sh);
            end
        end
        return n;
    endfunction

    function automatic logic [38:0] exp_of(input mdl_t m);
        return {m.x, m.ty, m.v, m.passed, m.st == 2'd1, m.st == 2'd2};
    endfunction

    function automatic logic [38:0] main_vec();
        return {bean_x, bean_type, bean_valid, bean_passed, running, frozen};
    endfunction

    function automatic logic [38:0] fast_vec();
        return {f_bean_x, f_bean_type, f_bean_valid, f_bean_passed, f_running, f_frozen};
    endfunction

    // Drives one clk of stimulus into the chosen instance and queues the expected outputs.
    task automatic applyStimulus(input bit fast, input bit tk, input bit st, input bit hit);
        tick      = fast ? 1'b0 : tk;
        start     = fast ? 1'b0 : st;
        check_hit = fast ? 1'b0 : hit;
        ftick     = fast ? tk : 1'b0;
        fstart    = fast ? st : 1'b0;
        fhit      = fast ? hit : 1'b0;
        m_main = model_next(m_main, tick, start, check_hit, 700, 5, 200);
        m_fast = model_next(m_fast, ftick, fstart, fhit, 1000, 15, 0);
        if (fast) q_fast.push_back(exp_of(m_fast));
        else      q_main.push_back(exp_of(m_main));
        @(posedge clk);
        #1;
        tick = 0; start = 0; check_hit = 0;
        ftick = 0; fstart = 0; fhit = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick = 0; start = 0; check_hit = 0; ftick = 0; fstart = 0; fhit = 0;
        m_main = model_reset();
        m_fast = model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (main_vec() !== 39'd0 || dut.lfsr_q !== 16'hACE1 || dut.gap_q !== 10'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_state: got %h lfsr %h gap %0d, expected 0 lfsr ace1 gap 0",
                     main_vec(), dut.lfsr_q, dut.gap_q);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 0);
            exp_v = q_main.pop_front();
            act_v = main_vec();
            n_cmp++;
            if (act_v !== exp_v || act_v !== 39'd0) begin
                n_bad++;
                $display("[TB] FAIL idle_tick: got %h expected %h", act_v, exp_v);
            end
        end
    endtask

    task automatic test_spawn();
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp_v = q_main.pop_front();
            act_v = main_vec();
            n_cmp++;
            if (act_v !== exp_v && i == 1) begin
                n_bad++;
                $display("[TB] FAIL first_spawn_sb: got %h expected %h", act_v, exp_v);
            end
        end
        n_cmp++;
        if (bean_x[9:0] !== 10'd700 || bean_type !== 3'b001 || bean_valid !== 3'b001 || !running) begin
            n_bad++;
            $display("[TB] FAIL first_spawn: got x %0d type %b valid %b run %b, expected 700 001 001 1",
                     bean_x[9:0], bean_type, bean_valid, running);
        end
        n_cmp++;
        if (dut.gap_q !== 10'd424 || dut.lfsr_q !== 16'h59C3) begin
            n_bad++;
            $display("[TB] FAIL first_gap: got gap %0d lfsr %h, expected 424 59c3", dut.gap_q, dut.lfsr_q);
        end
    endtask

    task automatic test_move();
        for (int i = 0; i < 84; i++) begin
            applyStimulus(0, 1, 0, 0);
            exp_v = q_main.pop_front();
            act_v = main_vec();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("[TB] FAIL move_tick%0d: got %h expected %h", i, act_v, exp_v);
            end
        end
        n_cmp++;
        if (bean_x[9:0] !== 10'd280 || bean_valid !== 3'b001 || dut.gap_q !== 10'd4) begin
            n_bad++;
            $display("[TB] FAIL move_84: got x %0d valid %b gap %0d, expected 280 001 4",
                     bean_x[9:0], bean_valid, dut.gap_q);
        end
        applyStimulus(0, 1, 0, 0);
        exp_v = q_main.pop_front();
        act_v = main_vec();
        n_cmp++;
        if (act_v !== exp_v || bean_valid !== 3'b011 || bean_x[19:0] !== {10'd700, 10'd275}) begin
            n_bad++;
            $display("[TB] FAIL second_spawn: got %h expected %h (slot1 700 slot0 275)", act_v, exp_v);
        end
    endtask

    task automatic test_retire();
        for (int i = 0; i < 54; i++) begin
            applyStimulus(0, 1, 0, 0);
            exp_v = q_main.pop_front();
            act_v = main_vec();
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("[TB] FAIL approach_tick%0d: got %h expected %h", i, act_v, exp_v);
            end
        end
        n_cmp++;
        if (bean_x[9:0] !== 10'd5) begin
            n_bad++;
            $display("[TB] FAIL edge_x: got %0d expected 5", bean_x[9:0]);
        end
        applyStimulus(0, 1, 0, 0);
        exp_v = q_main.pop_front();
        act_v = main_vec();
        n_cmp++;
        if (act_v !== exp_v || bean_valid[0] !== 1'b0 || bean_passed !== 1'b1 || bean_x[9:0] !== 10'd0) begin
            n_bad++;
            $display("[TB] FAIL retire: got %h expected %h (slot0 free, pass 1)", act_v, exp_v);
        end
        applyStimulus(0, 0, 0, 0);
        exp_v = q_main.pop_front();
        act_v = main_vec();
        n_cmp++;
        if (act_v !== exp_v || bean_passed !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL pass_pulse_width: got %h expected %h", act_v, exp_v);
        end
    endtask

    task automatic test_hit();
        logic [29:0] x_before;
        x_before = bean_x;
        applyStimulus(0, 1, 0, 1);
        exp_v = q_main.pop_front();
        act_v = main_vec();
        n_cmp++;
        if (act_v !== exp_v || bean_x !== x_before || frozen !== 1'b1 || running !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL hit_with_tick: got %h expected %h", act_v, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1);
            exp_v = q_main.pop_front();
            act_v = main_vec();
            n_cmp++;
            if (act_v !== exp_v || bean_x !== x_before) begin
                n_bad++;
                $display("[TB] FAIL frozen_tick%0d: got %h expected %h", i, act_v, exp_v);
            end
        end
        applyStimulus(0, 0, 1, 1);
        exp_v = q_main.pop_front();
        act_v = main_vec();
        n_cmp++;
        if (act_v !== exp_v || bean_valid !== 3'b000 || bean_x !== 30'd0 || running !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL restart: got %h expected %h", act_v, exp_v);
        end
    endtask

    task automatic test_full_slots();
        bit reached;
        bit retired;
        applyStimulus(1, 0, 1, 0);
        exp_v = q_fast.pop_front();
        act_v = fast_vec();
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL fast_start: got %h expected %h", act_v, exp_v);
        end
        reached = 1'b0;
        retired = 1'b0;
        for (int i = 0; i < 300 && !retired; i++) begin
            applyStimulus(1, 1, 0, 0);
            exp_v = q_fast.pop_front();
            act_v = fast_vec();
            n_cmp++;
            if (act_v !== exp_v || u_fast.gap_q !== m_fast.gap) begin
                n_bad++;
                $display("[TB] FAIL fast_tick%0d: got %h gap %0d expected %h gap %0d",
                         i, act_v, u_fast.gap_q, exp_v, m_fast.gap);
            end
            if (reached && m_fast.passed) begin
                retired = 1'b1;
                n_cmp++;
                if (f_bean_passed !== 1'b1 || f_bean_valid !== 3'b111 ||
                    (f_bean_x[9:0] !== 10'd1000 && f_bean_x[19:10] !== 10'd1000 &&
                     f_bean_x[29:20] !== 10'd1000)) begin
                    n_bad++;
                    $display("[TB] FAIL full_respawn: got pass %b valid %b x %h, expected 1 111 with a 1000",
                             f_bean_passed, f_bean_valid, f_bean_x);
                end
            end
            if (m_fast.v == 3'b111 && m_fast.gap <= 10'd15) reached = 1'b1;
        end
        n_cmp++;
        if (!reached || !retired) begin
            n_bad++;
            $display("[TB] FAIL full_timeout: got reached %b retired %b, expected 1 1", reached, retired);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(0, 1, 0, 0);
        exp_v = q_main.pop_front();
        act_v = main_vec();
        n_cmp++;
        if (act_v !== exp_v || bean_valid == 3'b000) begin
            n_bad++;
            $display("[TB] FAIL pre_reset: got %h expected %h", act_v, exp_v);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (main_vec() !== 39'd0 || fast_vec() !== 39'd0) begin
            n_bad++;
            $display("[TB] FAIL async_reset: got %h / %h expected 0", main_vec(), fast_vec());
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_main = model_reset();
        m_fast = model_reset();
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_move();
        test_retire();
        test_hit();
        test_full_slots();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
